// File: rtl/gups_pkg.sv
// Shared constants for the GUPS round-robin arbiter: default sizes, FSM encoding, index width helper.
package gups_pkg;

    localparam int NCH_DEF = 4;
    localparam int AW_DEF  = 64;
    localparam int DW_DEF  = 64;
    localparam int CW_DEF  = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic int idx_w(input int nch);
        return $clog2(nch);
    endfunction

endpackage

// File: rtl/gups_arb_rr_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping cyclically.
module rr_pick
    import gups_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int IW  = idx_w(NCH_DEF)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    output logic           o_valid,
    output logic [IW-1:0]  o_idx
);

    logic [2*NCH-1:0] w_dbl;
    logic [2*NCH-1:0] w_rot;
    logic [IW-1:0]    w_off;
    logic [IW:0]      w_sum;

    // Rotating the doubled vector right by ptr puts the search origin at bit 0.
    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = w_dbl >> i_ptr;
        w_off = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IW'(j);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (IW + 1)'(NCH)) begin
            w_sum = w_sum - (IW + 1)'(NCH);
        end
        o_valid = |i_req;
        o_idx   = w_sum[IW-1:0];
    end

endmodule

// File: rtl/gups_arb_rr.sv
// Round-robin arbiter from NCH GUPS requesters onto one memory port with back-to-back regrant.
// Optional per-channel completion counters are built when GUPS_ARB_STATS_EN is defined.
module gups_arb_rr
    import gups_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*AW-1:0]     addr_a,
    input  logic [NCH*DW-1:0]     dout_a,
    output logic [NCH*DW-1:0]     din_a,
    input  logic [NCH-1:0]        req_a,
    input  logic [NCH-1:0]        wr_a,
    output logic [NCH-1:0]        rdy_a,
    output logic [AW-1:0]         addr,
    output logic [DW-1:0]         dout,
    input  logic [DW-1:0]         din,
    output logic                  req,
    output logic                  wr,
    input  logic                  rdy,
`ifdef GUPS_ARB_STATS_EN
    output logic [NCH*CW-1:0]     stat_cnt,
`endif
    output logic [0:0]            o_dbg_state,
    output logic [idx_w(NCH)-1:0] o_dbg_gnt
);

    localparam int IW = idx_w(NCH);

    // Handshake: req_a[i] is held until rdy_a[i]; memory req stays high until the rdy pulse,
    // and rdy_a pulses for one cycle, combinationally, in the cycle memory asserts rdy.

    logic [0:0]     r_state;
    logic [IW-1:0]  r_gnt;
    logic [IW-1:0]  r_ptr;
    logic           r_req;
    logic           r_wr;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_dout;

    logic           w_done;
    logic [NCH-1:0] w_req_vec;
    logic [IW-1:0]  w_ptr_nxt;
    logic [IW-1:0]  w_pick_ptr;
    logic           w_pick_vld;
    logic [IW-1:0]  w_pick_idx;
    logic [AW-1:0]  w_addr_arr [NCH];
    logic [DW-1:0]  w_dout_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign w_addr_arr[g] = addr_a[g*AW +: AW];
        assign w_dout_arr[g] = dout_a[g*DW +: DW];
    end

    assign w_done     = (r_state == ST_BUSY) && rdy;
    assign w_ptr_nxt  = (r_gnt == IW'(NCH - 1)) ? '0 : r_gnt + IW'(1);
    // The completing channel is excluded so the others get the regrant first.
    assign w_req_vec  = w_done ? (req_a & ~(NCH'(1) << r_gnt)) : req_a;
    assign w_pick_ptr = w_done ? w_ptr_nxt : r_ptr;

    rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .i_req   (w_req_vec),
        .i_ptr   (w_pick_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_addr  <= w_addr_arr[w_pick_idx];
                        r_dout  <= w_dout_arr[w_pick_idx];
                        r_wr    <= wr_a[w_pick_idx];
                        r_gnt   <= w_pick_idx;
                        r_req   <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    if (rdy) begin
                        r_ptr <= w_ptr_nxt;
                        if (w_pick_vld) begin
                            r_addr <= w_addr_arr[w_pick_idx];
                            r_dout <= w_dout_arr[w_pick_idx];
                            r_wr   <= wr_a[w_pick_idx];
                            r_gnt  <= w_pick_idx;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign rdy_a       = w_done ? (NCH'(1) << r_gnt) : '0;
    assign din_a       = {NCH{din}};
    assign addr        = r_addr;
    assign dout        = r_dout;
    assign wr          = r_wr;
    assign req         = r_req;
    assign o_dbg_state = r_state;
    assign o_dbg_gnt   = r_gnt;

`ifdef GUPS_ARB_STATS_EN
    logic [CW-1:0] r_stat [NCH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                r_stat[i] <= '0;
            end else if (rdy_a[i]) begin
                r_stat[i] <= r_stat[i] + CW'(1);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_stat
        assign stat_cnt[g*CW +: CW] = r_stat[g];
    end
`endif

endmodule
